twin_register_write_arbiter: RTL
================================

Name: twin_register_write_arbiter

Overview:
Shares one 8-bit twin register pair (q1/q2) between two independent writers, A and B. A registered grant handshake and a round-robin arbiter decide the writer. A grant is held for bursts of up to MAX_BURST writes and then forcibly handed over if the other side is waiting. The block sits in front of the twin register datapath and is the only path by which the registers are written.

Parameters:
WIDTH, 8, data width of each register and each requester data bus.
MAX_BURST, 4, maximum consecutive accepted writes by one owner while the other requester is waiting (legal range 1..255).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous, active-low reset (rst=0 at a rising edge resets the block).
req_a  input  1  requester A wants to write; held high while it has writes pending.
sel_a  input  1  A target: 0 selects q1, 1 selects q2.
d_a  input  WIDTH  A write data.
req_b  input  1  requester B request.
sel_b  input  1  B target: 0 selects q1, 1 selects q2.
d_b  input  WIDTH  B write data.
gnt_a  output  1  registered grant to A.
gnt_b  output  1  registered grant to B.
busy  output  1  gnt_a | gnt_b.
q1  output  WIDTH  register 1 contents.
q2  output  WIDTH  register 2 contents.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, gnt_a=gnt_b=0, q1=q2=0, burst count=0, last_served=B (so A wins the first tie). Reset overrides all requests, including one mid-burst.
- States: IDLE, OWN_A, OWN_B. gnt_a=1 exactly in OWN_A; gnt_b=1 exactly in OWN_B; never both.
- Write acceptance: at an edge where the block is in OWN_x and req_x=1, the target register (sel_x) loads d_x. Otherwise q1/q2 hold.
- Latency: req rises in cycle N (IDLE), grant is visible in N+1, first write happens at the end of N+1, and the register value is visible in N+2. Back-to-back writes follow at one per cycle.
- IDLE: only one request → go to that owner. Both requesting → grant the one that is not last_served. No request → stay.
- OWN_x with req_x=0 at an edge: no write. If req_y=1, go directly to OWN_y (handoff, no IDLE bubble); else go to IDLE. last_served=x.
- Burst count increments on each accepted write in OWN_x. On the edge performing the MAX_BURST-th write:
  - If req_y=1, go to OWN_y, count=0, last_served=x.
  - Otherwise stay in OWN_x with count=0 (the burst window restarts).
- The count also clears on any ownership change or on entry to IDLE.
- The grant is registered, so a requester that drops req in the cycle it is granted loses that slot and performs no write.
- sel and d are sampled only from the current owner. The non-owner's inputs are ignored completely.
- MAX_BURST=1 gives strict per-write alternation under continuous contention.

Test Plan:
- Reset: drive rst=0 for 2 edges with req_a=req_b=1 → q1=q2=0, gnt_a=gnt_b=0, busy=0. Release rst → gnt_a=1 one cycle later (A wins the tie).
- Single writer: A writes sel_a=0,d=52, then sel_a=1,d=45, then drops req → q1=52 and q2=45 two and three cycles after req rises; gnt_a falls the cycle after req_a drops.
- Contention burst: req_a and req_b held high; A sends 11,16,36,63,99 to q1 and B sends 9 to q2 → q1 shows 11,16,36,63. gnt switches to B after A's 4th write, and q2=9 one cycle later. A's 99 is written only after B releases or completes its burst.
- Handoff without bubble: A owns, B requesting, A drops req → gnt_b=1 on the next cycle, gnt_a=0, and no cycle has busy=0.
- Uncontended burst overrun: A alone writes 6 values → all 6 land in consecutive cycles and gnt_a stays high throughout.
- Reset mid-burst: assert rst=0 after A's 2nd write → next cycle q1=q2=0, gnt_a=0. After release, the tie goes to A again (last_served=B).

Source files
------------

// File: rtl/twin_register_write_arbiter.sv
// twin_register_write_arbiter: arbitrates two writers (A, B) onto a shared q1/q2 register pair.
//   Round-robin tie-break, registered grants, and a forced handoff after MAX_BURST
//   consecutive writes when the other side is waiting.
//   Ports: clk, rst (sync, active-low); req_x/sel_x/d_x per writer (sel 0->q1, 1->q2);
//          gnt_a/gnt_b registered grants; busy = any grant; q1/q2 register contents.
module twin_register_write_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             sel_a,
   input  logic [WIDTH-1:0] d_a,
   input  logic             req_b,
   input  logic             sel_b,
   input  logic [WIDTH-1:0] d_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             busy,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2
);
   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
   state_t           state;
   logic [7:0]       cnt;
   logic             last_a;
   logic             is_a;
   logic             own_req;
   logic             oth_req;
   logic             own_sel;
   logic             burst_end;
   logic [WIDTH-1:0] own_d;
   // Only the current owner's inputs are ever looked at.
   always_comb begin
      is_a      = state == OWN_A;
      own_req   = is_a ? req_a : req_b;
      oth_req   = is_a ? req_b : req_a;
      own_sel   = is_a ? sel_a : sel_b;
      own_d     = is_a ? d_a : d_b;
      burst_end = cnt == 8'(MAX_BURST - 1);
   end
   assign busy = gnt_a | gnt_b;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         gnt_a  <= 1'b0;
         gnt_b  <= 1'b0;
         q1     <= '0;
         q2     <= '0;
         cnt    <= '0;
         last_a <= 1'b0;
      end else if (state == IDLE) begin
         cnt <= '0;
         // On a tie, the side that was not served last wins.
         if (req_a && (!req_b || !last_a)) begin
            state <= OWN_A;
            gnt_a <= 1'b1;
         end else if (req_b) begin
            state <= OWN_B;
            gnt_b <= 1'b1;
         end
      end else begin
         if (own_req) begin
            if (own_sel) q2 <= own_d;
            else q1 <= own_d;
         end
         if (own_req && !burst_end) begin
            cnt <= cnt + 8'd1;
         end else begin
            cnt <= '0;
            // Release, or forced handoff at burst end; an uncontended burst end just restarts the window.
            if (!own_req || oth_req) begin
               last_a <= is_a;
               state  <= oth_req ? (is_a ? OWN_B : OWN_A) : IDLE;
               gnt_a  <= oth_req && !is_a;
               gnt_b  <= oth_req && is_a;
            end
         end
      end
   end
endmodule
